// File: rtl/wram_loader_if.sv
// Bus bundle for the WRAM loader: the weight stream in, WRAM write port out, and session status.
// Stream handshake: a word transfers on a rising edge where in_valid and in_ready are both high.
interface wram_loader_if #(
  parameter int DATA_W     = 32,
  parameter int NUM_NEURON = 17,
  parameter int ADDR_W     = 3
);
  logic                  start;
  logic [DATA_W-1:0]     in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [NUM_NEURON-1:0] wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  busy;
  logic                  load_done;
  logic                  hdr_err;
  logic [1:0]            dbg_state;

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, busy, load_done, hdr_err, dbg_state
  );

  modport master (
    output start, in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, busy, load_done, hdr_err, dbg_state
  );
endinterface

// File: rtl/wram_loader.sv
// Run-time writer for the per-neuron weight RAMs: header word selects a neuron,
// the following WORDS_PER_N words are written to its WRAM at addresses 0..WORDS_PER_N-1.
module wram_loader #(
  parameter int DATA_W      = 32,
  parameter int NUM_NEURON  = 17,
  parameter int WORDS_PER_N = 8,
  parameter int ADDR_W      = 3,
  parameter int SEL_W       = 5
) (
  input  logic          clk,
  input  logic          reset,
  wram_loader_if.slave  bus
);
  localparam int CNT_W = (WORDS_PER_N > 1) ? $clog2(WORDS_PER_N) : 1;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(WORDS_PER_N - 1);
  localparam logic [SEL_W:0]   NUM_N  = (SEL_W + 1)'(NUM_NEURON);
  localparam logic [NUM_NEURON-1:0] ONE = {{(NUM_NEURON-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DROP} state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [SEL_W-1:0]      idx_q;
  logic [NUM_NEURON-1:0] mask_q;
  logic                  load_done_q;
  logic                  hdr_err_q;
  logic [NUM_NEURON-1:0] wr_en_q;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic [DATA_W-1:0]     wr_data_q;

  logic                  busy;
  logic                  in_ready;
  logic                  beat;
  logic                  last_word;
  logic                  hdr_ok;
  logic [SEL_W-1:0]      hdr_idx;
  logic [NUM_NEURON-1:0] neuron_bit;
  logic [NUM_NEURON-1:0] mask_d;

  // A start pulse takes priority over any beat presented in the same cycle.
  always_comb begin
    busy       = (state_q != S_IDLE);
    in_ready   = busy & ~bus.start;
    beat       = in_ready & bus.in_valid;
    hdr_idx    = bus.in_data[SEL_W-1:0];
    hdr_ok     = ({1'b0, hdr_idx} < NUM_N);
    last_word  = (cnt_q == LAST);
    neuron_bit = ONE << idx_q;
    mask_d     = mask_q | neuron_bit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      mask_q      <= '0;
      load_done_q <= 1'b0;
      hdr_err_q   <= 1'b0;
      wr_en_q     <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      wr_en_q <= '0;
      if (bus.start) begin
        state_q     <= S_HDR;
        cnt_q       <= '0;
        mask_q      <= '0;
        hdr_err_q   <= 1'b0;
        load_done_q <= 1'b0;
      end else if (beat) begin
        case (state_q)
          S_HDR: begin
            cnt_q <= '0;
            if (hdr_ok) begin
              idx_q   <= hdr_idx;
              state_q <= S_DATA;
            end else begin
              hdr_err_q <= 1'b1;
              state_q   <= S_DROP;
            end
          end
          S_DATA: begin
            wr_en_q   <= neuron_bit;
            wr_addr_q <= ADDR_W'(cnt_q);
            wr_data_q <= bus.in_data;
            if (last_word) begin
              cnt_q       <= '0;
              mask_q      <= mask_d;
              load_done_q <= &mask_d;
              // The session closes on the same edge that completes the mask.
              state_q     <= (&mask_d) ? S_IDLE : S_HDR;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_DROP: begin
            if (last_word) begin
              cnt_q   <= '0;
              state_q <= S_HDR;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.load_done = load_done_q;
  assign bus.hdr_err   = hdr_err_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_wram_loader.sv
// Directed bench for wram_loader: drives header/weight frames and scoreboards every WRAM write.
module tb_wram_loader;
  localparam int DATA_W      = 32;
  localparam int NUM_NEURON  = 17;
  localparam int WORDS_PER_N = 8;
  localparam int ADDR_W      = 3;
  localparam int SEL_W       = 5;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wram_loader_if #(.DATA_W(DATA_W), .NUM_NEURON(NUM_NEURON), .ADDR_W(ADDR_W)) bus ();

  wram_loader #(
    .DATA_W(DATA_W), .NUM_NEURON(NUM_NEURON), .WORDS_PER_N(WORDS_PER_N),
    .ADDR_W(ADDR_W), .SEL_W(SEL_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_tests  = 0;
  int n_fail   = 0;
  int n_writes = 0;

  // expected write entry: {neuron idx[4:0], addr[2:0], data[31:0]}
  logic [39:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [39:0] e;
    if (bus.wr_en != '0) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 64'(bus.wr_en), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_en",   64'(bus.wr_en),   64'd1 << e[39:35]);
        check("wr_addr", 64'(bus.wr_addr), 64'(e[34:32]));
        check("wr_data", 64'(bus.wr_data), 64'(e[31:0]));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_word(input logic [31:0] w);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    #1 check("in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
  endtask

  task automatic send_data(input int idx, input int k, input logic [31:0] base);
    if (idx < NUM_NEURON) exp_q.push_back({5'(idx), 3'(k), base + 32'(k)});
    send_word(base + 32'(k));
  endtask

  // header plus nwords weight words; gap inserts one idle cycle before each weight word
  task automatic send_frame(input int idx, input logic [31:0] base, input bit gap, input int nwords);
    send_word(32'hFFFF_FF00 | 32'(idx));
    for (int k = 0; k < nwords; k++) begin
      if (gap) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      send_data(idx, k, base);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
  endtask

  task automatic pulse_start(input bit with_valid, input logic [31:0] w);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.in_valid = with_valid;
    bus.in_data  = w;
    #1 check("start_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    #2;
    check("start_busy",      64'(bus.busy),      64'd1);
    check("start_load_done", 64'(bus.load_done), 64'd0);
    check("start_hdr_err",   64'(bus.hdr_err),   64'd0);
  endtask

  task automatic full_load(input string tag);
    for (int i = 0; i < NUM_NEURON; i++) begin
      send_frame(i, 32'(i * 16), 1'b0, WORDS_PER_N);
      if (i == NUM_NEURON - 2) begin
        #1 check({tag, "_done_early"}, 64'(bus.load_done), 64'd0);
      end
    end
    settle();
    check({tag, "_load_done"}, 64'(bus.load_done), 64'd1);
    check({tag, "_busy"},      64'(bus.busy),      64'd0);
    check({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
    check({tag, "_sb_empty"},  64'(exp_q.size()),  64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
    check({tag, "_busy"},      64'(bus.busy),      64'd0);
    check({tag, "_load_done"}, 64'(bus.load_done), 64'd0);
    check({tag, "_hdr_err"},   64'(bus.hdr_err),   64'd0);
    check({tag, "_wr_en"},     64'(bus.wr_en),     64'd0);
    check({tag, "_wr_addr"},   64'(bus.wr_addr),   64'd0);
    check({tag, "_wr_data"},   64'(bus.wr_data),   64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w6;
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = $urandom_range(0, 32'hFFFF);

    // T1: reset held low with valid asserted
    #8;
    check_idle_outputs("t1_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1 check("t1_idle_in_ready", 64'(bus.in_ready), 64'd0);
    check("t1_idle_busy", 64'(bus.busy), 64'd0);
    bus.in_valid = 1'b0;

    // T2: full load, continuous valid
    pulse_start(1'b0, 32'd0);
    full_load("t2");
    check("t2_writes", 64'(n_writes), 64'd136);

    // T3: out-of-range header is dropped, next frame writes
    pulse_start(1'b0, 32'd0);
    send_frame(20, 32'h0000_5000, 1'b0, WORDS_PER_N);
    settle();
    check("t3_hdr_err", 64'(bus.hdr_err), 64'd1);
    check("t3_writes",  64'(n_writes),    64'd136);
    send_frame(3, 32'd48, 1'b0, WORDS_PER_N);
    settle();
    check("t3_hdr_err_sticky", 64'(bus.hdr_err),   64'd1);
    check("t3_load_done",      64'(bus.load_done), 64'd0);
    check("t3_busy",           64'(bus.busy),      64'd1);
    check("t3_sb_empty",       64'(exp_q.size()),  64'd0);

    // T4: all but neuron 5 (with a reload of 0), then 5 with gapped valid
    pulse_start(1'b0, 32'd0);
    send_frame(0, 32'h0000_0100, 1'b0, WORDS_PER_N);
    for (int i = 1; i < NUM_NEURON; i++)
      if (i != 5) send_frame(i, 32'(i * 16), 1'b0, WORDS_PER_N);
    send_frame(0, 32'd0, 1'b0, WORDS_PER_N);
    settle();
    check("t4_done_before_5", 64'(bus.load_done), 64'd0);
    send_frame(5, 32'd80, 1'b1, WORDS_PER_N - 1);
    settle();
    check("t4_done_before_w7", 64'(bus.load_done), 64'd0);
    check("t4_busy_before_w7", 64'(bus.busy),      64'd1);
    send_data(5, WORDS_PER_N - 1, 32'd80);
    settle();
    check("t4_load_done", 64'(bus.load_done), 64'd1);
    check("t4_busy",      64'(bus.busy),      64'd0);
    check("t4_sb_empty",  64'(exp_q.size()),  64'd0);

    // T5: start aborts a frame of neuron 2; start coincident with a beat
    pulse_start(1'b0, 32'd0);
    send_frame(20, 32'h0000_6000, 1'b0, WORDS_PER_N);
    settle();
    check("t5_hdr_err", 64'(bus.hdr_err), 64'd1);
    send_frame(2, 32'd32, 1'b0, 4);
    pulse_start(1'b1, 32'd36);
    send_frame(7, 32'd112, 1'b0, WORDS_PER_N);
    settle();
    check("t5_hdr_err_after", 64'(bus.hdr_err),   64'd0);
    check("t5_load_done",     64'(bus.load_done), 64'd0);
    check("t5_busy",          64'(bus.busy),      64'd1);
    check("t5_sb_empty",      64'(exp_q.size()),  64'd0);

    // T6: asynchronous reset after word 4, then a clean full load
    send_frame(9, 32'd144, 1'b0, 5);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 reset = 1'b0;
    #1 check_idle_outputs("t6_reset");
    check("t6_sb_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pulse_start(1'b0, 32'd0);
    full_load("t6");

    w6 = 136 + 8 + 144 + 12 + 5 + 136;
    check("total_writes", 64'(n_writes), 64'(w6));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
